// File: rtl/mod_updown_counter_pkg.sv
// Shared constants for the counter family.
// Mode encoding for the wrap/saturate policy input.
package mod_updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic is_sat(input logic mode);
    return mode == MODE_SAT;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle of the up/down counter.
// master drives controls; slave is the counter.
interface mod_updown_counter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
);

  logic              en;
  logic              up;
  logic              sat;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf;
  logic              udf;
  logic              at_max;
  logic              at_zero;

  modport master (
    output en, up, sat, load, load_val,
    output limit, step, clr_flags,
    input  count, tc, ovf, udf,
    input  at_max, at_zero
  );

  modport slave (
    input  en, up, sat, load, load_val,
    input  limit, step, clr_flags,
    output count, tc, ovf, udf,
    output at_max, at_zero
  );

endinterface

// File: rtl/mod_updown_counter_next.sv
// Next-count arithmetic for the modulo counter.
// Pure combinational; sums kept one bit wider.
module mod_updown_next
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic              sat,
  output logic [WIDTH-1:0]  next_count,
  output logic              cross_up,
  output logic              cross_dn
);

  localparam int EW =
    ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [EW-1:0] c_x;
  logic [EW-1:0] l_x;
  logic [EW-1:0] l1_x;
  logic [EW-1:0] st_x;
  logic [EW-1:0] s_x;
  logic [EW-1:0] sum_x;
  logic [EW-1:0] wup_x;
  logic [EW-1:0] wdn_x;
  logic [EW-1:0] dif_x;
  logic          sat_m;

  // clamp the step to the modulus and pick the next count
  always_comb begin
    c_x   = EW'(count);
    l_x   = EW'(limit);
    l1_x  = l_x + EW'(1);
    st_x  = EW'(step);
    s_x   = (st_x > l1_x) ? l1_x : st_x;
    sum_x = c_x + s_x;
    wup_x = sum_x - l1_x;
    wdn_x = c_x + l1_x - s_x;
    dif_x = c_x - s_x;
    sat_m = is_sat(sat);
    next_count = count;
    cross_up   = 1'b0;
    cross_dn   = 1'b0;
    if (s_x == '0) begin
      next_count = count;
    end else if (c_x > l_x) begin
      if (up) begin
        next_count = sat_m ? limit : '0;
        cross_up   = 1'b1;
      end else begin
        next_count = limit;
      end
    end else if (up) begin
      if (sum_x <= l_x) begin
        next_count = WIDTH'(sum_x);
      end else begin
        next_count = sat_m ? limit : WIDTH'(wup_x);
        cross_up   = 1'b1;
      end
    end else begin
      if (s_x <= c_x) begin
        next_count = WIDTH'(dif_x);
      end else begin
        next_count = sat_m ? '0 : WIDTH'(wdn_x);
        cross_dn   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus.
// Registers, load/enable priority, tc and sticky flags.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input logic                clk,
  input logic                reset,
  mod_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;
  logic [WIDTH-1:0] next_count;
  logic             cross_up;
  logic             cross_dn;
  logic [WIDTH-1:0] load_clip;

  mod_updown_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count      (count_q),
    .limit      (bus.limit),
    .step       (bus.step),
    .up         (bus.up),
    .sat        (bus.sat),
    .next_count (next_count),
    .cross_up   (cross_up),
    .cross_dn   (cross_dn)
  );

  // load beats count; a crossing beats a flag clear
  always_comb begin
    load_clip = (bus.load_val > bus.limit) ?
                bus.limit : bus.load_val;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_flags;
    udf_d   = udf_q & ~bus.clr_flags;
    if (bus.load) begin
      count_d = load_clip;
    end else if (bus.en) begin
      count_d = next_count;
      tc_d    = cross_up | cross_dn;
      ovf_d   = ovf_d | cross_up;
      udf_d   = udf_d | cross_dn;
    end
  end

  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;
  assign bus.at_max  = (count_q == bus.limit);
  assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter.
// Expected values are hand-computed per step.
module tb_mod_updown_counter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mod_updown_counter_if #(.WIDTH(4), .STEP_W(2)) bus ();

  mod_updown_counter #(.WIDTH(4), .STEP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input int c,
                        input int t, input int o,
                        input int u);
    chk({tag, ".count"}, int'(bus.count), c);
    chk({tag, ".tc"},    int'(bus.tc),    t);
    chk({tag, ".ovf"},   int'(bus.ovf),   o);
    chk({tag, ".udf"},   int'(bus.udf),   u);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.up        = 1'b1;
    bus.sat       = 1'b0;
    bus.load      = 1'b0;
    bus.load_val  = 4'd0;
    bus.limit     = 4'd9;
    bus.step      = 2'd1;
    bus.clr_flags = 1'b0;
    #23;
    chk_st("rst", 0, 0, 0, 0);
    chk("rst.at_zero", int'(bus.at_zero), 1);
    chk("rst.at_max",  int'(bus.at_max),  0);
    reset = 1'b0;
    tick();

    // wrap up 0..9,0,1
    bus.en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_st($sformatf("wup%0d", i), i % 10,
             (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0, 0);
    end

    // hold with en low
    bus.en = 1'b0;
    tick();
    chk_st("hold", 1, 0, 1, 0);

    // step 0 enabled holds
    bus.en   = 1'b1;
    bus.step = 2'd0;
    tick();
    chk_st("step0", 1, 0, 1, 0);

    // load 7 then async reset between edges
    bus.en       = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    tick();
    chk_st("ld7", 7, 0, 1, 0);
    bus.load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_st("arst", 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    tick();
    chk_st("arst_post", 0, 0, 0, 0);

    // wrap down by 3 from 2
    bus.load     = 1'b1;
    bus.load_val = 4'd2;
    tick();
    chk_st("ld2", 2, 0, 0, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b0;
    bus.step = 2'd3;
    tick();
    chk_st("wdn1", 9, 1, 0, 1);
    chk("wdn1.at_max", int'(bus.at_max), 1);
    tick();
    chk_st("wdn2", 6, 0, 0, 1);
    tick();
    chk_st("wdn3", 3, 0, 0, 1);
    tick();
    chk_st("wdn4", 0, 0, 0, 1);
    chk("wdn4.at_zero", int'(bus.at_zero), 1);
    tick();
    chk_st("wdn5", 7, 1, 0, 1);

    // clear flags without a crossing
    bus.en        = 1'b0;
    bus.clr_flags = 1'b1;
    tick();
    chk_st("clr", 7, 0, 0, 0);
    bus.clr_flags = 1'b0;

    // saturate up from 7 by 3
    bus.load     = 1'b1;
    bus.load_val = 4'd7;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.sat  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_st($sformatf("sup%0d", i), 9, 1, 1, 0);
    end

    // saturate down from 1 by 2
    bus.en       = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd1;
    tick();
    chk_st("ld1", 1, 0, 1, 0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    bus.up   = 1'b0;
    bus.step = 2'd2;
    tick();
    chk_st("sdn", 0, 1, 1, 1);

    // load beats en and clips to limit
    bus.load     = 1'b1;
    bus.load_val = 4'd12;
    tick();
    chk_st("ldclip", 9, 0, 1, 1);

    // clear coinciding with crossing
    bus.load      = 1'b0;
    bus.sat       = 1'b0;
    bus.up        = 1'b1;
    bus.step      = 2'd1;
    bus.clr_flags = 1'b1;
    tick();
    chk_st("clrx", 0, 1, 1, 0);
    bus.clr_flags = 1'b0;

    // limit 0 pins count, each step crosses
    bus.limit = 4'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_st($sformatf("lim0_%0d", i), 0, 1, 1, 0);
    end
    chk("lim0.at_max", int'(bus.at_max), 1);
    bus.up = 1'b0;
    tick();
    chk_st("lim0dn", 0, 1, 1, 1);

    // out of range, up, wrap
    bus.en        = 1'b0;
    bus.limit     = 4'd9;
    bus.load      = 1'b1;
    bus.load_val  = 4'd8;
    bus.clr_flags = 1'b1;
    tick();
    chk_st("ld8a", 8, 0, 0, 0);
    bus.load      = 1'b0;
    bus.clr_flags = 1'b0;
    bus.limit     = 4'd5;
    bus.up        = 1'b1;
    bus.en        = 1'b1;
    tick();
    chk_st("oor_up", 0, 1, 1, 0);

    // out of range, down
    bus.en        = 1'b0;
    bus.limit     = 4'd9;
    bus.load      = 1'b1;
    bus.clr_flags = 1'b1;
    tick();
    chk_st("ld8b", 8, 0, 0, 0);
    bus.load      = 1'b0;
    bus.clr_flags = 1'b0;
    bus.limit     = 4'd5;
    bus.up        = 1'b0;
    bus.en        = 1'b1;
    tick();
    chk_st("oor_dn", 5, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
